// File: rtl/ajul_j_pkg.sv
// ajul_j_pkg: shared constants for the 4-bit even up/down counter
package ajul_j_pkg;
  localparam int W = 4;
  localparam logic [W-1:0] STEP = 4'd2;
  localparam logic [W-1:0] RST_S = 4'd0;
endpackage

// File: rtl/ajul_j_t_ff.sv
// t_ff: T flip-flop with asynchronous active-low reset
module t_ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_t,
  output logic o_q
);
  logic r_q;
  // toggle on rising edge when i_t is high; reset clears immediately
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_q <= 1'b0;
    else r_q <= r_q ^ i_t;
  assign o_q = r_q;
endmodule

// File: rtl/ajul_j.sv
// ajul_j: 4-bit step-by-2 up/down counter built from T flip-flops; optional TC output under AJULJ_TC_EN
module ajul_j
  import ajul_j_pkg::*;
(
  output logic Q3,
  output logic Q2,
  output logic Q1,
  output logic Q0,
  input  logic Y,
  input  logic reset,
  input  logic clk
`ifdef AJULJ_TC_EN
  ,
  output logic TC
`endif
);
  logic [W-1:0] w_q;
  logic [W-1:0] w_t;
  // T0=Q0 clears any odd state; T1 always toggles; upper toggles follow the carry/borrow chain
  assign w_t[0] = w_q[0];
  assign w_t[1] = 1'b1;
  assign w_t[2] = Y ? ~w_q[1] : w_q[1];
  assign w_t[3] = Y ? (~w_q[1] & ~w_q[2]) : (w_q[1] & w_q[2]);
  for (genvar i = 0; i < W; i++) begin : g_bit
    t_ff u_tff (
      .clk  (clk),
      .rst_n(reset),
      .i_t  (w_t[i]),
      .o_q  (w_q[i])
    );
  end
  assign {Q3, Q2, Q1, Q0} = w_q;
`ifdef AJULJ_TC_EN
  // terminal count: the state that wraps on the next step in the selected direction
  assign TC = reset & (Y ? (w_q == RST_S) : (w_q == RST_S - STEP));
`endif
endmodule

// File: tb/tb_ajul_j.sv
// tb_ajul_j: scoreboard bench for the ajul_j even up/down counter
module tb_ajul_j;
  logic Q3, Q2, Q1, Q0, Y, reset, clk;
  logic [3:0] S;
  logic [3:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
`ifdef AJULJ_TC_EN
  logic TC;
`endif

  ajul_j dut (
    .Q3(Q3), .Q2(Q2), .Q1(Q1), .Q0(Q0), .Y(Y), .reset(reset), .clk(clk)
`ifdef AJULJ_TC_EN
    , .TC(TC)
`endif
  );

  assign S = {Q3, Q2, Q1, Q0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic push_step(input logic y, input logic [3:0] e);
    @(negedge clk);
    Y = y;
    exp_q.push_back(e);
  endtask

  // monitor: after each rising edge, pop the expected state and compare
  always @(posedge clk) begin
    logic [3:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("state", S, e);
`ifdef AJULJ_TC_EN
      chk("tc", {3'b0, TC}, {3'b0, reset && (Y ? (e == 4'd0) : (e == 4'd14))});
`endif
    end
  end

  initial begin
    #5000;
    $display("FAIL watchdog: timeout at t=%0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    Y = 1'b0;
    exp_q.push_back(4'd0);
    #1 chk("rst_async", S, 4'd0);
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back(4'd2);
    for (int i = 2; i <= 8; i++) push_step(1'b0, 4'((2 * i) % 16));
    for (int i = 1; i <= 8; i++) push_step(1'b1, 4'((16 - 2 * i) % 16));
    for (int i = 1; i <= 5; i++) push_step(1'b0, 4'(2 * i));
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("rst_mid", S, 4'd0);
`ifdef AJULJ_TC_EN
    chk("tc_rst", {3'b0, TC}, 4'd0);
`endif
    exp_q.push_back(4'd0);
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back(4'd2);
    push_step(1'b0, 4'd4);
    @(negedge clk);
    force dut.g_bit[0].u_tff.r_q = 1'b1;
    #1 release dut.g_bit[0].u_tff.r_q;
    #1 chk("force_odd", S, 4'd5);
    exp_q.push_back(4'd6);
    push_step(1'b1, 4'd4);
    push_step(1'b0, 4'd6);
    push_step(1'b1, 4'd4);
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 4'(exp_q.size()), 4'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ajul_j.md
AJUL_J -- requirements
Module: ajul_j

Interface
REQ-001 Parameters: none; width fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low forces state 0000.
REQ-004 Y  input  1  direction select; 0 = count up, 1 = count down.
REQ-005 Q3  output  1  state bit 3 (MSB), registered.
REQ-006 Q2  output  1  state bit 2, registered.
REQ-007 Q1  output  1  state bit 1, registered.
REQ-008 Q0  output  1  state bit 0 (LSB), registered; 0 in every legal state.
REQ-009 Port order shall be Q3, Q2, Q1, Q0, Y, reset, clk; clocking is one clock, and reset is asynchronous and active-low.

Function
REQ-010 State S = {Q3,Q2,Q1,Q0}; legal states are even values 0000,0010,...,1110.
REQ-011 Rising clk edge with reset high, Y=0: S <= (S+2) mod 16; 1110 wraps to 0000.
REQ-012 Rising clk edge with reset high, Y=1: S <= (S-2) mod 16; 0000 wraps to 1110.
REQ-013 Y is sampled only at the rising edge; a Y change between edges alters only the next step's direction, with no glitch on Q.
REQ-014 Latency: one clk edge per step; no hold/enable state; the counter steps on every edge while reset is high.
REQ-015 Toggle equations: T0=Q0; T1=1; up: T2=Q1, T3=Q1&Q2; down: T2=~Q1, T3=~Q1&~Q2.
REQ-016 Illegal odd state (Q0=1) shall self-clear: Q0 returns to 0 on the next edge while the upper bits step per REQ-015.
REQ-017 Direction reversal: the step after Y changes moves by 2 in the new direction from the current S (e.g., 0100 up->down gives 0010).

Reset
REQ-018 reset low shall drive Q3..Q0 to 0000 immediately, independent of clk.
REQ-019 While reset is low, S holds 0000 through all clk edges.
REQ-020 After reset deassertion, the first step occurs at the first rising edge that samples reset high.
REQ-021 Reset asserted mid-count shall abort the count and return to 0000 with no partial update.

Configuration
REQ-022 Macro AJULJ_TC_EN: when defined, add output TC (1 bit, after clk in port order).
REQ-023 TC is combinational: 1 when (Y=0 and S=1110) or (Y=1 and S=0000); otherwise 0. TC is forced to 0 while reset is low.
REQ-024 Without AJULJ_TC_EN, TC does not exist and behaviour is otherwise identical.

Structure
REQ-025 Shared package ajul_j_pkg: width constant (4), step constant (2), and reset-state constant (0000).
REQ-026 One sub-module t_ff: a T flip-flop with clk, active-low async reset, T in, Q out. Q toggles on a rising edge when T=1.
REQ-027 Top level is structural: four t_ff instances plus the gate-level toggle logic of REQ-015.

Verification (clk period 10, first rise at t=5; reset low until t=10; Y=0 until t=90, then Y=1)
REQ-028 t=0..10, reset low: S=0000; the edge at t=5 is ignored.
REQ-029 Y=0, edges t=15..85: S = 0010,0100,0110,1000,1010,1100,1110,0000 (wrap at t=85).
REQ-030 Y=1, edges t=95..165: S = 1110,1100,1010,1000,0110,0100,0010,0000 (underflow wrap at t=95).
REQ-031 Assert reset low at S=1010 between edges: S=0000 at once, before the next edge; counting restarts at 0010 on the first edge after release.
REQ-032 Force Q0=1 (S=0101), Y=0, one edge: S=0110. Q0 stays 0 in every cycle of the runs above.
REQ-033 With AJULJ_TC_EN defined: TC=1 exactly when Y=0 with S=1110, and when Y=1 with S=0000; TC=0 during reset.
